hms_time_keeper: RTL and testbench

- Time-of-day keeper. Holds hours, minutes and seconds as binary counters and advances them on a 1 Hz tick pulse.
- Provides a two-button set mode with a blinking decimal-point indicator on the field being edited.
- Upstream: a tick generator that produces one `clk`-wide pulse per second.
- Downstream: per-field two-digit splitters, seven-segment decoders and the six-digit multiplexed display driver. `o_dp` feeds the driver's six decimal-point inputs directly.

---
 rtl/hms_time_keeper.sv | 132 +++++++++++++
 tb/tb_hms_time_keeper.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_time_keeper.sv
// Time-of-day keeper: binary hh:mm:ss advanced by a 1 Hz tick, with a
// two-button set mode and a blinking decimal-point marker on the edited field.
module hms_time_keeper #(
    parameter int unsigned HOUR_MAX      = 23,
    parameter bit          SET_SEC_CLEAR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic [1:0] o_mode,
    output logic [5:0] o_dp,
    output logic       o_day_pulse
);

    localparam int unsigned TW        = 6;
    localparam logic [TW-1:0] SEC_LAST  = TW'(59);
    localparam logic [TW-1:0] HOUR_LAST = TW'(HOUR_MAX);

    typedef enum logic [1:0] {
        CLOCK    = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] sec_n, min_n, hour_n, dp_n;
    logic          blink, blink_n;
    logic          day_n;
    logic          mode_q, inc_q;
    logic          mode_press, inc_press;

    // Increment with wrap back to zero after the field's last value.
    function automatic logic [TW-1:0] inc_wrap(input logic [TW-1:0] v,
                                               input logic [TW-1:0] last);
        return (v == last) ? '0 : v + TW'(1);
    endfunction

    // Rising-edge detection against the per-button history registers.
    assign mode_press = i_btn_mode & ~mode_q;
    assign inc_press  = i_btn_inc  & ~inc_q;
    assign o_mode     = state;

    // State, time, blink and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLOCK;
            o_sec       <= '0;
            o_min       <= '0;
            o_hour      <= '0;
            o_dp        <= '0;
            o_day_pulse <= 1'b0;
            blink       <= 1'b0;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
        end else begin
            state       <= state_n;
            o_sec       <= sec_n;
            o_min       <= min_n;
            o_hour      <= hour_n;
            o_dp        <= dp_n;
            o_day_pulse <= day_n;
            blink       <= blink_n;
            mode_q      <= i_btn_mode;
            inc_q       <= i_btn_inc;
        end
    end

    // Next-state, time update, blink phase and decimal-point pattern.
    always_comb begin
        state_n = state;
        sec_n   = o_sec;
        min_n   = o_min;
        hour_n  = o_hour;
        blink_n = blink;
        day_n   = 1'b0;
        dp_n    = '0;

        case (state)
            CLOCK: begin
                if (i_tick) begin
                    sec_n = inc_wrap(o_sec, SEC_LAST);
                    if (o_sec == SEC_LAST) begin
                        min_n = inc_wrap(o_min, SEC_LAST);
                        if (o_min == SEC_LAST) begin
                            hour_n = inc_wrap(o_hour, HOUR_LAST);
                            day_n  = (o_hour == HOUR_LAST);
                        end
                    end
                end
                if (mode_press) begin
                    state_n = SET_SEC;
                    blink_n = 1'b1;
                end
            end
            default: begin
                if (mode_press) begin
                    // Mode wins over inc and tick; leaving SET_HOUR ends editing.
                    case (state)
                        SET_SEC: state_n = SET_MIN;
                        SET_MIN: state_n = SET_HOUR;
                        default: state_n = CLOCK;
                    endcase
                    blink_n = (state != SET_HOUR);
                end else if (inc_press) begin
                    // Edit only the selected field, no carry; light it at once.
                    blink_n = 1'b1;
                    case (state)
                        SET_SEC: sec_n  = SET_SEC_CLEAR ? '0 : inc_wrap(o_sec, SEC_LAST);
                        SET_MIN: min_n  = inc_wrap(o_min, SEC_LAST);
                        default: hour_n = inc_wrap(o_hour, HOUR_LAST);
                    endcase
                end else if (i_tick) begin
                    blink_n = ~blink;
                end
            end
        endcase

        case (state_n)
            SET_SEC:  dp_n = {4'b0000, blink_n, blink_n};
            SET_MIN:  dp_n = {2'b00, blink_n, blink_n, 2'b00};
            SET_HOUR: dp_n = {blink_n, blink_n, 4'b0000};
            default:  dp_n = '0;
        endcase
    end

endmodule

// File: tb/tb_hms_time_keeper.sv
// Directed bench for hms_time_keeper with an expected-value scoreboard.
`timescale 1ns/1ps
module tb_hms_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_btn_mode = 1'b0;
    logic       i_btn_inc = 1'b0;
    logic [5:0] o_sec, o_min, o_hour, o_dp;
    logic [1:0] o_mode;
    logic       o_day_pulse;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [5:0] hour;
        logic [1:0] mode;
        logic [5:0] dp;
        logic       day;
    } exp_t;

    exp_t exp_q[$];
    int   compares = 0;
    int   fails    = 0;

    hms_time_keeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (i_tick),
        .i_btn_mode  (i_btn_mode),
        .i_btn_inc   (i_btn_inc),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_mode      (o_mode),
        .o_dp        (o_dp),
        .o_day_pulse (o_day_pulse)
    );

    always #10 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want summary before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input int got, input int want);
        compares++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic sb_push(input int s, input int m, input int h, input int mo,
                           input logic [5:0] dp, input logic day);
        exp_t e;
        e.sec  = 6'(s);
        e.min  = 6'(m);
        e.hour = 6'(h);
        e.mode = 2'(mo);
        e.dp   = dp;
        e.day  = day;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            compares++;
            fails++;
            $error("FAIL %s: got empty scoreboard want entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".sec"},  int'(o_sec),       int'(e.sec));
            cmp({tag, ".min"},  int'(o_min),       int'(e.min));
            cmp({tag, ".hour"}, int'(o_hour),      int'(e.hour));
            cmp({tag, ".mode"}, int'(o_mode),      int'(e.mode));
            cmp({tag, ".dp"},   int'(o_dp),        int'(e.dp));
            cmp({tag, ".day"},  int'(o_day_pulse), int'(e.day));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick1();
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick1();
            cyc(1);
        end
    endtask

    task automatic press_mode();
        i_btn_mode = 1'b1;
        @(negedge clk);
        i_btn_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic incs(input int n);
        repeat (n) begin
            i_btn_inc = 1'b1;
            @(negedge clk);
            i_btn_inc = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state, during and after reset.
        cyc(3);
        sb_push(0, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("reset");
        rst_n = 1'b1;
        cyc(2);
        sb_push(0, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("post_reset");

        // 61 ticks spaced 10 cycles apart.
        repeat (61) begin
            tick1();
            cyc(9);
        end
        sb_push(1, 1, 0, 0, 6'b000000, 1'b0);
        sb_check("61ticks");

        // Preload 23:59:00 via set mode, then tick up to the rollover.
        press_mode();
        sb_push(1, 1, 0, 1, 6'b000011, 1'b0);
        sb_check("enter_set_sec");
        incs(1);
        sb_push(0, 1, 0, 1, 6'b000011, 1'b0);
        sb_check("sec_clear");
        press_mode();
        sb_push(0, 1, 0, 2, 6'b001100, 1'b0);
        sb_check("enter_set_min");
        incs(58);
        sb_push(0, 59, 0, 2, 6'b001100, 1'b0);
        sb_check("min59");
        press_mode();
        sb_push(0, 59, 0, 3, 6'b110000, 1'b0);
        sb_check("enter_set_hour");
        incs(23);
        sb_push(0, 59, 23, 3, 6'b110000, 1'b0);
        sb_check("hour23");
        press_mode();
        sb_push(0, 59, 23, 0, 6'b000000, 1'b0);
        sb_check("back_clock");
        ticks(58);
        sb_push(58, 59, 23, 0, 6'b000000, 1'b0);
        sb_check("preload");
        tick1();
        sb_push(59, 59, 23, 0, 6'b000000, 1'b0);
        sb_check("235959");
        cyc(1);
        tick1();
        sb_push(0, 0, 0, 0, 6'b000000, 1'b1);
        sb_check("rollover");
        cyc(1);
        sb_push(0, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("pulse_one_cycle");

        // Minute editing with wrap, no carry, seconds frozen, blink on ticks.
        ticks(3);
        press_mode();
        press_mode();
        incs(58);
        sb_push(3, 58, 0, 2, 6'b001100, 1'b0);
        sb_check("min58");
        incs(1);
        sb_push(3, 59, 0, 2, 6'b001100, 1'b0);
        sb_check("min_inc1");
        incs(1);
        sb_push(3, 0, 0, 2, 6'b001100, 1'b0);
        sb_check("min_wrap");
        incs(1);
        sb_push(3, 1, 0, 2, 6'b001100, 1'b0);
        sb_check("min_inc3");
        tick1();
        sb_push(3, 1, 0, 2, 6'b000000, 1'b0);
        sb_check("blink_off");
        cyc(1);
        tick1();
        sb_push(3, 1, 0, 2, 6'b001100, 1'b0);
        sb_check("blink_on");
        cyc(1);

        // Held inc in SET_HOUR gives exactly one increment.
        press_mode();
        sb_push(3, 1, 0, 3, 6'b110000, 1'b0);
        sb_check("set_hour");
        i_btn_inc = 1'b1;
        cyc(100);
        i_btn_inc = 1'b0;
        cyc(1);
        sb_push(3, 1, 1, 3, 6'b110000, 1'b0);
        sb_check("held_inc");

        // Mode and inc together in SET_SEC: mode wins.
        press_mode();
        sb_push(3, 1, 1, 0, 6'b000000, 1'b0);
        sb_check("clock2");
        press_mode();
        i_btn_mode = 1'b1;
        i_btn_inc  = 1'b1;
        cyc(1);
        i_btn_mode = 1'b0;
        i_btn_inc  = 1'b0;
        cyc(1);
        sb_push(3, 1, 1, 2, 6'b001100, 1'b0);
        sb_check("mode_wins");

        // Tick and mode together in CLOCK at sec=5.
        press_mode();
        press_mode();
        ticks(2);
        sb_push(5, 1, 1, 0, 6'b000000, 1'b0);
        sb_check("sec5");
        i_tick     = 1'b1;
        i_btn_mode = 1'b1;
        cyc(1);
        i_tick     = 1'b0;
        i_btn_mode = 1'b0;
        sb_push(6, 1, 1, 1, 6'b000011, 1'b0);
        sb_check("tick_mode");
        cyc(1);

        // Build 12:34:56, enter SET_HOUR, then reset asynchronously.
        incs(1);
        press_mode();
        incs(33);
        press_mode();
        incs(11);
        press_mode();
        ticks(56);
        sb_push(56, 34, 12, 0, 6'b000000, 1'b0);
        sb_check("t123456");
        press_mode();
        press_mode();
        press_mode();
        sb_push(56, 34, 12, 3, 6'b110000, 1'b0);
        sb_check("set_hour2");
        #2;
        i_btn_mode = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        sb_push(0, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("async_reset");

        // Mode button held across reset release is ignored until re-pressed.
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        sb_push(0, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("held_mode_ignored");
        i_btn_mode = 1'b0;
        cyc(1);
        press_mode();
        sb_push(0, 0, 0, 1, 6'b000011, 1'b0);
        sb_check("repress");
        press_mode();
        press_mode();
        press_mode();
        tick1();
        sb_push(1, 0, 0, 0, 6'b000000, 1'b0);
        sb_check("first_tick");
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
